// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and helpers for the round-robin bus arbiter
// Purpose: FSM state encoding, address field width and the destination
//          extraction helper used by bus_rr_arbiter.
// Ports:   none (package).
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    POP,
    PUSH
  } arb_state_t;

  localparam int ADDR_W    = 8;
  // Widest packet dest_of() accepts; callers zero-extend into this width.
  localparam int MAX_PKT_W = 64;

  // Destination address lives in the top ADDR_W bits of a pkt_w-bit packet.
  function automatic logic [ADDR_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                input int                   pkt_w);
    return ADDR_W'(pkt >> (pkt_w - ADDR_W));
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_picker.sv
// rtl/bus_rr_arbiter_picker.sv - rotating-priority request picker
// Purpose: combinational round-robin search. Starting at ptr_i and wrapping
//          modulo drvrs, returns the first asserted request.
// Ports:
//   req_i    in   drvrs   request vector
//   ptr_i    in   PTR_W   index with highest priority this round
//   grant_o  out  drvrs   one-hot grant (zero when no request)
//   idx_o    out  PTR_W   index of the granted request
//   valid_o  out  1       at least one request was found
module rr_prio_picker #(
  parameter int drvrs = 4,
  parameter int PTR_W = $clog2(drvrs)
) (
  input  logic [drvrs-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [drvrs-1:0] grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  int               j;
  logic [PTR_W-1:0] j_idx;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    j_idx   = '0;
    for (int i = 0; i < drvrs; i++) begin
      // ptr_i < drvrs, so one subtraction is enough to wrap.
      j = int'(ptr_i) + i;
      if (j >= drvrs) j = j - drvrs;
      j_idx = PTR_W'(j);
      if (!valid_o && req_i[j_idx]) begin
        valid_o        = 1'b1;
        grant_o[j_idx] = 1'b1;
        idx_o          = j_idx;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin scheduler for one broadcast-capable bus
// Purpose: picks a device FIFO with pending data, pops its head packet and
//          pushes it to the addressed device, or to every other device when
//          the address equals broadcast. One packet per 4 cycles at most.
// Optional feature: define BUS_ARB_DROP_CNT_EN to add drop_cnt, a saturating
//          count of packets dropped for an invalid destination address.
// Ports:
//   clk       in   1                 bus clock, rising edge
//   reset     in   1                 asynchronous, active-high
//   pndng     in   drvrs             device FIFO non-empty flags
//   D_pop     in   drvrs x pckg_sz   head-of-FIFO packet per device
//   pop       out  drvrs             one-cycle pop strobe to the source FIFO
//   push      out  drvrs             one-cycle write strobe to destination(s)
//   D_push    out  pckg_sz           packet on the bus while push is active
//   busy      out  1                 FSM is not in IDLE
//   drop_cnt  out  16                invalid-destination drops (optional)
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int                drvrs     = 4,
  parameter int                pckg_sz   = 16,
  parameter logic [ADDR_W-1:0] broadcast = 8'hFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [drvrs-1:0]               pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]  D_pop,
  output logic [drvrs-1:0]               pop,
  output logic [drvrs-1:0]               push,
  output logic [pckg_sz-1:0]             D_push,
  output logic                           busy
`ifdef BUS_ARB_DROP_CNT_EN
  ,
  output logic [15:0]                    drop_cnt
`endif
);

  localparam int PTR_W = $clog2(drvrs);

  arb_state_t          state_q,   state_d;
  logic [PTR_W-1:0]    rr_ptr_q,  rr_ptr_d;
  logic [PTR_W-1:0]    win_idx_q, win_idx_d;
  logic [drvrs-1:0]    win_oh_q,  win_oh_d;
  logic [PTR_W-1:0]    src_q,     src_d;
  logic [pckg_sz-1:0]  pkt_q,     pkt_d;
  logic [drvrs-1:0]    pop_q,     pop_d;
  logic [drvrs-1:0]    push_q,    push_d;
  logic [pckg_sz-1:0]  d_push_q,  d_push_d;
  logic                busy_q,    busy_d;

  logic [drvrs-1:0]    pick_grant;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_valid;
  logic [ADDR_W-1:0]   dest;

  rr_prio_picker #(
    .drvrs (drvrs),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i   (pndng),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign dest = dest_of(MAX_PKT_W'(pkt_q), pckg_sz);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_idx_d = win_idx_q;
    win_oh_d  = win_oh_q;
    src_d     = src_q;
    pkt_d     = pkt_q;
    pop_d     = '0;
    push_d    = '0;
    d_push_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_idx_d = pick_idx;
          win_oh_d  = pick_grant;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        // Winner may have withdrawn its request since it was sampled; in that
        // case abandon the round without touching the pointer.
        if (|(pndng & win_oh_q)) begin
          pkt_d    = D_pop[win_idx_q];
          src_d    = win_idx_q;
          rr_ptr_d = (int'(win_idx_q) == drvrs - 1) ? '0 : win_idx_q + PTR_W'(1);
          state_d  = POP;
        end else begin
          state_d  = IDLE;
        end
      end
      POP: begin
        for (int i = 0; i < drvrs; i++) pop_d[i] = (src_q == PTR_W'(i));
        state_d = PUSH;
      end
      PUSH: begin
        d_push_d = pkt_q;
        // Broadcast is checked first so it wins even if it aliases a device id.
        if (dest == broadcast) begin
          for (int i = 0; i < drvrs; i++) push_d[i] = (src_q != PTR_W'(i));
        end else if (int'(dest) < drvrs) begin
          for (int i = 0; i < drvrs; i++) push_d[i] = (dest == ADDR_W'(i));
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      win_idx_q <= '0;
      win_oh_q  <= '0;
      src_q     <= '0;
      pkt_q     <= '0;
      pop_q     <= '0;
      push_q    <= '0;
      d_push_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_idx_q <= win_idx_d;
      win_oh_q  <= win_oh_d;
      src_q     <= src_d;
      pkt_q     <= pkt_d;
      pop_q     <= pop_d;
      push_q    <= push_d;
      d_push_q  <= d_push_d;
      busy_q    <= busy_d;
    end
  end

  assign pop    = pop_q;
  assign push   = push_q;
  assign D_push = d_push_q;
  assign busy   = busy_q;

`ifdef BUS_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  assign drop = (state_q == PUSH) && (dest != broadcast) && (int'(dest) >= drvrs);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - directed self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

  logic              clk;
  logic              rst;
  logic [3:0]        pndng;
  logic [3:0][15:0]  d_pop;
  logic [3:0]        pop;
  logic [3:0]        push;
  logic [15:0]       d_push;
  logic              busy;
`ifdef BUS_ARB_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  bus_rr_arbiter #(
    .drvrs     (4),
    .pckg_sz   (16),
    .broadcast (8'hFF)
  ) dut (
    .clk    (clk),
    .reset  (rst),
    .pndng  (pndng),
    .D_pop  (d_pop),
    .pop    (pop),
    .push   (push),
    .D_push (d_push),
    .busy   (busy)
`ifdef BUS_ARB_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst   = 1'b1;
    pndng = '0;
    d_pop = '0;
    repeat (2) cycle();
    chk("reset_pop", pop, 4'b0000);
    chk("reset_push", push, 4'b0000);
    chk("reset_dpush", d_push, 16'h0000);
    chk("reset_busy", busy, 1'b0);
`ifdef BUS_ARB_DROP_CNT_EN
    chk("reset_drop_cnt", drop_cnt, 16'h0000);
`endif
    rst = 1'b0;
    cycle();
    chk("idle_busy", busy, 1'b0);

    // Single packet from dev1 to dev2.
    d_pop[1] = 16'h02AB;
    pndng    = 4'b0010;
    cycle();
    chk("t1_busy_capture", busy, 1'b1);
    chk("t1_pop_e0", pop, 4'b0000);
    cycle();
    chk("t1_pop_e1", pop, 4'b0000);
    cycle();
    chk("t1_pop_e2", pop, 4'b0010);
    chk("t1_push_e2", push, 4'b0000);
    pndng = 4'b0000;
    cycle();
    chk("t1_push_e3", push, 4'b0100);
    chk("t1_dpush_e3", d_push, 16'h02AB);
    chk("t1_pop_e3", pop, 4'b0000);
    chk("t1_busy_e3", busy, 1'b0);
    cycle();
    chk("t1_push_e4", push, 4'b0000);

    // All devices pending: grants 0,1,2,3,0 every 4 cycles; dev i sends to i+1.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    d_pop[0] = 16'h0110;
    d_pop[1] = 16'h0211;
    d_pop[2] = 16'h0312;
    d_pop[3] = 16'h0013;
    pndng    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      repeat (3) cycle();
      chk($sformatf("t2_pop_%0d", k), pop, 4'b0001 << g);
      cycle();
      chk($sformatf("t2_push_%0d", k), push, 4'b0001 << ((g + 1) % 4));
    end
    chk("t2_dpush_last", d_push, 16'h0110);

    // Broadcast from dev2 (rr_ptr now 1).
    pndng    = 4'b0100;
    d_pop[2] = 16'hFF5A;
    repeat (3) cycle();
    chk("t3_pop", pop, 4'b0100);
    pndng = 4'b0000;
    cycle();
    chk("t3_push", push, 4'b1011);
    chk("t3_dpush", d_push, 16'hFF5A);
    cycle();
    chk("t3_push_clr", push, 4'b0000);
    chk("t3_dpush_clr", d_push, 16'h0000);

    // Invalid destination 7 from dev0: popped but dropped.
    pndng    = 4'b0001;
    d_pop[0] = 16'h0711;
    repeat (3) cycle();
    chk("t4_pop", pop, 4'b0001);
    pndng = 4'b0000;
    cycle();
    chk("t4_push", push, 4'b0000);
    chk("t4_busy", busy, 1'b0);
`ifdef BUS_ARB_DROP_CNT_EN
    chk("t4_drop_cnt", drop_cnt, 16'h0001);
`endif

    // Reset while the pop strobe is live; pointer must return to 0.
    pndng    = 4'b0010;
    d_pop[1] = 16'h0012;
    repeat (3) cycle();
    chk("t5_pop_live", pop, 4'b0010);
    chk("t5_busy_live", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_pop", pop, 4'b0000);
    chk("t5_async_push", push, 4'b0000);
    chk("t5_async_busy", busy, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    pndng    = 4'b0101;
    d_pop[0] = 16'h0133;
    d_pop[2] = 16'h0244;
    repeat (3) cycle();
    chk("t5_pop_after_reset", pop, 4'b0001);
    pndng = 4'b0000;
    cycle();
    chk("t5_push_after_reset", push, 4'b0010);
    chk("t5_dpush_after_reset", d_push, 16'h0133);

    // Winner withdraws before CAPTURE: no pop, no push, back to IDLE.
    cycle();
    pndng    = 4'b1000;
    d_pop[3] = 16'h0055;
    cycle();
    chk("t6_busy_capture", busy, 1'b1);
    pndng = 4'b0000;
    cycle();
    chk("t6_busy_abort", busy, 1'b0);
    chk("t6_pop_abort", pop, 4'b0000);
    cycle();
    chk("t6_pop_quiet", pop, 4'b0000);
    chk("t6_push_quiet", push, 4'b0000);
    // Pointer was left at 1 by the dev0 grant, so dev1 beats dev3.
    pndng    = 4'b1010;
    d_pop[1] = 16'h0366;
    repeat (3) cycle();
    chk("t6_pop_ptr_kept", pop, 4'b0010);
    pndng = 4'b0000;
    cycle();
    chk("t6_push_ptr_kept", push, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
